lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load/store unit between the core's execute stage and the RAM data port (port 2).
//  Handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW: byte-lane extraction with sign/zero extension,
//  and read-modify-write for sub-word stores, because the RAM writes whole words only.
//  RAM port 2 has a combinational read (rd2 follows addr2) and a write on the rising clk edge.
//  Misaligned, out-of-range and illegal-funct3 accesses return an error and never touch memory.
// PARAMETERS
//  START_ADDR  32'h8000_0000  byte address of RAM word 0
//  MEM_SIZE    16384          RAM size in bytes; valid range is [START_ADDR, START_ADDR+MEM_SIZE)
// PORTS
//  clk         in   1   clock; all state updates on the rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  req_valid   in   1   core request valid
//  req_ready   out  1   high only in IDLE; request accepted when req_valid && req_ready
//  req_we      in   1   1=store, 0=load
//  req_funct3  in   3   RV32I funct3 (LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data; the low byte/half/word is used
//  rsp_valid   out  1   one-cycle completion pulse; no backpressure
//  rsp_rdata   out  32  load result, extended; 0 for stores and errors
//  rsp_err     out  1   valid with rsp_valid; 1 = misaligned, out of range or illegal funct3
//  mem_addr    out  32  word-aligned address to RAM addr2; 0 in IDLE
//  mem_we      out  1   RAM we2; high only in ST_WR
//  mem_wd      out  32  RAM wd2; merged word in ST_WR, 0 otherwise
//  mem_rd      in   32  RAM rd2
// BEHAVIOUR
//  Reset: state=IDLE, all request registers cleared. Outputs after reset: req_ready=1,
//   rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_addr=0, mem_we=0, mem_wd=0.
//  Accept edge (cycle 0): latch addr, funct3, we and wdata. Compute err from the latched inputs:
//   half access with addr[0]=1; word access with addr[1:0]!=0; addr outside range;
//   load funct3 in {011,11x}; store funct3 > 010.
//  States: IDLE, LOAD, ST_RD, ST_WR, RESP. mem_addr = {addr[31:2],2'b00} in LOAD/ST_RD/ST_WR.
//   IDLE  -> RESP on accept with err; LOAD on accept with load; ST_WR on accept with SW;
//            ST_RD on accept with SB/SH
//   LOAD  -> RESP; registers mem_rd >> (8*addr[1:0]), then sign- or zero-extends per funct3
//   ST_RD -> ST_WR; registers mem_rd as old word
//   ST_WR -> RESP; mem_we=1, mem_wd = old word with the selected lane(s) replaced by wdata
//            (SW: mem_wd = wdata)
//   RESP  -> IDLE; rsp_valid=1 for exactly one cycle
//  Latency (rsp_valid cycle, after the cycle-0 accept edge): error=1, load=2, SW=2, SB/SH=3.
//   Throughput: the next request is accepted in the cycle after RESP.
//  Range check uses 33-bit arithmetic, so START_ADDR+MEM_SIZE cannot wrap.
//   The last valid word is START_ADDR+MEM_SIZE-4.
//  Error path: mem_we stays 0, rsp_rdata=0. Stores return rsp_rdata=0, rsp_err=0.
//  Reset mid-operation: rst_n low forces IDLE at once. mem_we drops to 0 with no clock edge.
//   A store that has not reached its ST_WR edge leaves memory unchanged. No rsp_valid for it.
//  req_* inputs are ignored outside IDLE.
// STRUCTURE
//  lsu_pkg: F3_* funct3 constants, the lsu_state_t enum, and a WORD_BYTES=4 localparam.
//  lsu_align: combinational sub-module with two functions:
//   load_extract(word, offset, funct3) -> 32b; store_merge(old, wdata, offset, funct3) -> 32b.
//  Top level: FSM plus request/response registers.
// TESTING
//  Bench instantiates lsu + ram (START_ADDR 32'h8000_0000, MEM_SIZE 16384) and preloads the word
//  at 0x8000_0004 = 0x8765_43F1.
//  1 LB 0x8000_0004 -> rsp_rdata 0xFFFF_FFF1 at cycle 2, err 0.
//    LBU at the same address -> 0x0000_00F1.
//  2 LH 0x8000_0006 -> 0xFFFF_8765. LHU 0x8000_0006 -> 0x0000_8765.
//    LB 0x8000_0007 -> 0xFFFF_FF87.
//  3 SB 0x8000_0005, wdata 0x0000_00AB -> mem_we high only in cycle 2, word becomes 0x8765_ABF1,
//    rsp at cycle 3. SH 0x8000_0006, wdata 0xBEEF -> word 0xBEEF_ABF1.
//  4 SW 0x8000_0000, wdata 0x1234_5678 -> mem_we in cycle 1, rsp at cycle 2.
//    LW 0x8000_0000 -> 0x1234_5678.
//  5 LW 0x8000_0002, SH 0x8000_0001, SW 0x7FFF_FFFC, LW 0x8000_4000, load funct3 011
//    -> each gives rsp_err=1 at cycle 1, mem_we never asserted.
//    LW 0x8000_3FFC -> err 0.
//  6 SH 0x8000_0004, then pull rst_n low during ST_RD -> req_ready=1 immediately,
//    word still 0x8765_43F1, no rsp_valid. A following LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and state type for the load/store unit.
package lsu_pkg;

   localparam int WORD_BYTES = 4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ST_RD,
      ST_WR,
      RESP
   } lsu_state_t;

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response bundle of the load/store unit.
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane handling: load extraction with extension and sub-word store merge.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] ld_word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic [31:0] st_data
);

   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (f3)
         F3_B:    load_extract = {{24{sh[7]}}, sh[7:0]};
         F3_H:    load_extract = {{16{sh[15]}}, sh[15:0]};
         F3_W:    load_extract = word;
         F3_BU:   load_extract = {24'h0, sh[7:0]};
         F3_HU:   load_extract = {16'h0, sh[15:0]};
         default: load_extract = 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
      logic [31:0] m;
      m = old;
      case (f3)
         F3_B:    m[{off, 3'b000} +: 8]       = wd[7:0];
         F3_H:    m[{off[1], 4'b0000} +: 16]  = wd[15:0];
         F3_W:    m = wd;
         default: m = old;
      endcase
      return m;
   endfunction

   assign ld_data = load_extract(ld_word, offset, funct3);
   assign st_data = store_merge(old_word, wdata, offset, funct3);

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit in front of a word-write RAM port; sub-word stores use read-modify-write.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// LOAD  | RAM read address presented, extended result captured at the edge
// ST_RD | sub-word store: capture the old word
// ST_WR | RAM write of the merged (or full) word
// RESP  | one-cycle response pulse
module lsu
   import lsu_pkg::*;
#(
   parameter logic [31:0] START_ADDR = 32'h8000_0000,
   parameter int unsigned MEM_SIZE   = 16384
) (
   input  logic        clk,
   input  logic        rst_n,
   lsu_if.slave        bus,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   lsu_state_t  state;
   logic [31:0] addr_q;
   logic [2:0]  f3_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic [31:0] old_q;
   logic [31:0] rdata_q;

   logic        in_range;
   logic        bad_f3;
   logic        misalign;
   logic        req_err;
   logic [31:0] ld_data;
   logic [31:0] st_data;

   // 33-bit compare so the range end cannot wrap past 2^32.
   always_comb begin
      in_range = ({1'b0, bus.req_addr} >= {1'b0, START_ADDR}) &&
                 ({1'b0, bus.req_addr} < ({1'b0, START_ADDR} + 33'(MEM_SIZE)));
      bad_f3   = bus.req_we ? (bus.req_funct3 > F3_W)
                            : ((bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11));
      misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
      req_err  = bad_f3 || misalign || !in_range;
   end

   lsu_align u_align (
      .ld_word  (mem_rd),
      .offset   (addr_q[1:0]),
      .funct3   (f3_q),
      .old_word (old_q),
      .wdata    (wdata_q),
      .ld_data  (ld_data),
      .st_data  (st_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         addr_q  <= '0;
         f3_q    <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         old_q   <= '0;
         rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  addr_q  <= bus.req_addr;
                  f3_q    <= bus.req_funct3;
                  wdata_q <= bus.req_wdata;
                  err_q   <= req_err;
                  old_q   <= '0;
                  rdata_q <= '0;
                  if (req_err)                   state <= RESP;
                  else if (!bus.req_we)          state <= LOAD;
                  else if (bus.req_funct3 == F3_W) state <= ST_WR;
                  else                           state <= ST_RD;
               end
            end
            LOAD: begin
               rdata_q <= ld_data;
               state   <= RESP;
            end
            ST_RD: begin
               old_q <= mem_rd;
               state <= ST_WR;
            end
            ST_WR:   state <= RESP;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_rdata = (state == RESP) ? rdata_q : 32'h0;
   assign bus.rsp_err   = (state == RESP) && err_q;

   assign mem_addr = ((state == LOAD) || (state == ST_RD) || (state == ST_WR))
                     ? (addr_q & ~32'(WORD_BYTES - 1)) : 32'h0;
   assign mem_we   = (state == ST_WR);
   assign mem_wd   = (state == ST_WR) ? st_data : 32'h0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a behavioural RAM: vector table plus reset-abort sequences.
module tb_lsu;
   import lsu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
   logic [31:0] ram [0:4095];

   lsu_if bus ();

   lsu #(.START_ADDR(32'h8000_0000), .MEM_SIZE(16384)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .mem_addr (mem_addr),
      .mem_we   (mem_we),
      .mem_wd   (mem_wd),
      .mem_rd   (mem_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rd = ram[mem_addr[13:2]];
   always @(posedge clk) if (mem_we) ram[mem_addr[13:2]] <= mem_wd;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          we_cyc;
      int          chk_idx;
      logic [31:0] chk_word;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vecs [NVEC];

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (vec %0d): got %h, want %h", nm, id, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v, input int id);
      int  lat_seen = 0;
      int  we_seen = 0;
      int  we_cnt = 0;
      logic [31:0] rd = 32'h0;
      logic        er = 1'b0;
      @(negedge clk);
      check("req_ready_idle", id, {31'h0, bus.req_ready}, 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_we     = v.we;
      bus.req_funct3 = v.f3;
      bus.req_addr   = v.addr;
      bus.req_wdata  = v.wdata;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      for (int c = 1; c <= 6 && lat_seen == 0; c++) begin
         @(negedge clk);
         if (mem_we) begin
            we_seen = c;
            we_cnt++;
         end
         if (bus.rsp_valid) begin
            lat_seen = c;
            rd = bus.rsp_rdata;
            er = bus.rsp_err;
         end
      end
      check("latency", id, 32'(lat_seen), 32'(v.lat));
      check("rsp_rdata", id, rd, v.rdata);
      check("rsp_err", id, {31'h0, er}, {31'h0, v.err});
      check("mem_we_cycle", id, 32'(we_seen), 32'(v.we_cyc));
      check("mem_we_count", id, 32'(we_cnt), (v.we_cyc != 0) ? 32'd1 : 32'd0);
      if (v.chk_idx >= 0) check("ram_word", id, ram[v.chk_idx], v.chk_word);
   endtask

   initial begin
      bit saw;
      vec_t lw;

      for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
      ram[1]    = 32'h8765_43F1;
      ram[4095] = 32'hCAFE_F00D;

      //         we    f3      addr          wdata         err   rdata         lat we  idx word
      vecs[0]  = '{1'b0, F3_B,  32'h8000_0004, 32'h0,        1'b0, 32'hFFFF_FFF1, 2, 0, -1, 32'h0};
      vecs[1]  = '{1'b0, F3_BU, 32'h8000_0004, 32'h0,        1'b0, 32'h0000_00F1, 2, 0, -1, 32'h0};
      vecs[2]  = '{1'b0, F3_H,  32'h8000_0006, 32'h0,        1'b0, 32'hFFFF_8765, 2, 0, -1, 32'h0};
      vecs[3]  = '{1'b0, F3_HU, 32'h8000_0006, 32'h0,        1'b0, 32'h0000_8765, 2, 0, -1, 32'h0};
      vecs[4]  = '{1'b0, F3_B,  32'h8000_0007, 32'h0,        1'b0, 32'hFFFF_FF87, 2, 0, -1, 32'h0};
      vecs[5]  = '{1'b1, F3_B,  32'h8000_0005, 32'h0000_00AB, 1'b0, 32'h0,        3, 2,  1, 32'h8765_ABF1};
      vecs[6]  = '{1'b1, F3_H,  32'h8000_0006, 32'h0000_BEEF, 1'b0, 32'h0,        3, 2,  1, 32'hBEEF_ABF1};
      vecs[7]  = '{1'b1, F3_W,  32'h8000_0000, 32'h1234_5678, 1'b0, 32'h0,        2, 1,  0, 32'h1234_5678};
      vecs[8]  = '{1'b0, F3_W,  32'h8000_0000, 32'h0,        1'b0, 32'h1234_5678, 2, 0, -1, 32'h0};
      vecs[9]  = '{1'b0, F3_W,  32'h8000_0002, 32'h0,        1'b1, 32'h0,         1, 0, -1, 32'h0};
      vecs[10] = '{1'b1, F3_H,  32'h8000_0001, 32'h0000_FFFF, 1'b1, 32'h0,        1, 0,  0, 32'h1234_5678};
      vecs[11] = '{1'b1, F3_W,  32'h7FFF_FFFC, 32'hFFFF_FFFF, 1'b1, 32'h0,        1, 0, -1, 32'h0};
      vecs[12] = '{1'b0, F3_W,  32'h8000_4000, 32'h0,        1'b1, 32'h0,         1, 0, -1, 32'h0};
      vecs[13] = '{1'b0, 3'b011, 32'h8000_0000, 32'h0,       1'b1, 32'h0,         1, 0, -1, 32'h0};
      vecs[14] = '{1'b1, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0,       1, 0,  0, 32'h1234_5678};
      vecs[15] = '{1'b0, F3_W,  32'h8000_3FFC, 32'h0,        1'b0, 32'hCAFE_F00D, 2, 0, -1, 32'h0};
      vecs[16] = '{1'b0, F3_HU, 32'h8000_0004, 32'h0,        1'b0, 32'h0000_ABF1, 2, 0, -1, 32'h0};
      vecs[17] = '{1'b1, F3_B,  32'h8000_0007, 32'hFFFF_FF12, 1'b0, 32'h0,        3, 2,  1, 32'h12EF_ABF1};
      vecs[18] = '{1'b0, 3'b110, 32'h8000_0004, 32'h0,       1'b1, 32'h0,         1, 0, -1, 32'h0};
      vecs[19] = '{1'b1, F3_W,  32'h8000_0004, 32'h8765_43F1, 1'b0, 32'h0,        2, 1,  1, 32'h8765_43F1};

      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      #12;
      check("rst_req_ready", -1, {31'h0, bus.req_ready}, 32'd1);
      check("rst_rsp_valid", -1, {31'h0, bus.rsp_valid}, 32'd0);
      check("rst_rsp_rdata", -1, bus.rsp_rdata, 32'h0);
      check("rst_rsp_err",   -1, {31'h0, bus.rsp_err}, 32'd0);
      check("rst_mem_addr",  -1, mem_addr, 32'h0);
      check("rst_mem_we",    -1, {31'h0, mem_we}, 32'd0);
      check("rst_mem_wd",    -1, mem_wd, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) run_op(vecs[i], i);

      // Reset while a half-word store sits in ST_RD: memory untouched, no response.
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = F3_H;
      bus.req_addr   = 32'h8000_0004;
      bus.req_wdata  = 32'h0000_1111;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      check("strd_mem_addr", 100, mem_addr, 32'h8000_0004);
      check("strd_ready", 100, {31'h0, bus.req_ready}, 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("abort_ready", 100, {31'h0, bus.req_ready}, 32'd1);
      check("abort_mem_addr", 100, mem_addr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      saw = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.rsp_valid) saw = 1'b1;
      end
      check("abort_no_rsp", 100, {31'h0, saw}, 32'd0);
      check("abort_ram", 100, ram[1], 32'h8765_43F1);

      // Reset during ST_WR: mem_we must drop asynchronously and no write may land.
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = F3_W;
      bus.req_addr   = 32'h8000_0004;
      bus.req_wdata  = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      check("stwr_mem_we", 101, {31'h0, mem_we}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_mem_we", 101, {31'h0, mem_we}, 32'd0);
      check("abort_mem_wd", 101, mem_wd, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_ram_sw", 101, ram[1], 32'h8765_43F1);

      lw = '{1'b0, F3_W, 32'h8000_0004, 32'h0, 1'b0, 32'h8765_43F1, 2, 0, -1, 32'h0};
      run_op(lw, 102);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
